// File: rtl/max_select_ctrl.sv
// -----------------------------------------------------------------------------
// max_select_ctrl
//
// Holds NUM candidate entries {x, y, w, d} and, on request, scans them one per
// clock to find the largest entry. Entries are ordered lexicographically
// (unsigned): d first, then x, then y, then w. A full tie keeps the running
// best, so the lowest index wins.
//
// Optional feature macro: MAXSEL_MASK_EN
//   When defined, the entry_en port exists. It is captured on the accepting
//   edge and masked-off entries can never become best. Masked entries still
//   take their scan cycle, so latency does not depend on the mask.
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   wr_en      : write one entry this cycle (only in IDLE/DONE, not with start)
//   wr_addr    : entry index to write (>= NUM ignored)
//   wr_x/wr_y  : 8-bit candidate fields
//   wr_w       : 4-bit candidate field
//   wr_d       : 17-bit candidate field, primary key
//   start      : one-cycle scan request, accepted only in IDLE
//   entry_en   : per-entry participation mask (MAXSEL_MASK_EN only)
//   busy       : high while scanning (NUM-1 cycles)
//   done       : one-cycle completion pulse
//   best_idx   : winning entry index, held until the next accepted start
//   best_d     : d field of the winner
//   best_found : at least one entry participated
// -----------------------------------------------------------------------------
module max_select_ctrl #(
    parameter int NUM = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [2:0]      wr_addr,
    input  logic [7:0]      wr_x,
    input  logic [7:0]      wr_y,
    input  logic [3:0]      wr_w,
    input  logic [16:0]     wr_d,
    input  logic            start,
`ifdef MAXSEL_MASK_EN
    input  logic [NUM-1:0]  entry_en,
`endif
    output logic            busy,
    output logic            done,
    output logic [2:0]      best_idx,
    output logic [16:0]     best_d,
    output logic            best_found
);

    // Key layout {d, x, y, w}: a plain unsigned compare of the packed key
    // gives exactly the required lexicographic priority.
    localparam int          KW   = 37;
    localparam logic [2:0]  LAST = 3'(NUM - 1);
    localparam logic [3:0]  NUM4 = 4'(NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [2:0]      pointer_reg;
    logic [KW-1:0]   entry_mem [NUM];
    logic [KW-1:0]   best_key_reg;
    logic [2:0]      best_idx_reg;
    logic            valid_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [KW-1:0]   wr_key;
    logic            wr_ok;
    logic [NUM-1:0]  entry_we;
    logic [KW-1:0]   chal_key;
    logic            chal_en;
    logic            first_en;

    assign wr_key   = {wr_d, wr_x, wr_y, wr_w};
    assign chal_key = entry_mem[pointer_reg];

    // Writes are taken only when no scan is running, and never on the same
    // edge that accepts a start, so the scanned data is a stable snapshot.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM4) &&
                   ((state_reg == ST_DONE) ||
                    ((state_reg == ST_IDLE) && !start));

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_we
            assign entry_we[gi] = wr_ok && (wr_addr == 3'(gi));
        end
    endgenerate

`ifdef MAXSEL_MASK_EN
    logic [NUM-1:0] mask_reg;

    assign first_en = entry_en[0];
    assign chal_en  = mask_reg[pointer_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            mask_reg <= entry_en;
        end
    end
`else
    assign first_en = 1'b1;
    assign chal_en  = 1'b1;
`endif

    // Candidate storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (rst) begin
                entry_mem[i] <= '0;
            end else if (entry_we[i]) begin
                entry_mem[i] <= wr_key;
            end
        end
    end

    // Scan FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pointer_reg  <= '0;
            best_key_reg <= '0;
            best_idx_reg <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg    <= ST_SCAN;
                        busy_reg     <= 1'b1;
                        pointer_reg  <= 3'd1;
                        best_idx_reg <= '0;
                        // A masked entry 0 leaves the running best invalid so
                        // the first enabled challenger is taken outright.
                        if (first_en) begin
                            best_key_reg <= entry_mem[0];
                            valid_reg    <= 1'b1;
                        end else begin
                            best_key_reg <= '0;
                            valid_reg    <= 1'b0;
                        end
                    end
                end
                ST_SCAN: begin
                    // Strictly greater only: ties keep the lower index.
                    if (chal_en && (!valid_reg || (chal_key > best_key_reg))) begin
                        best_key_reg <= chal_key;
                        best_idx_reg <= pointer_reg;
                        valid_reg    <= 1'b1;
                    end
                    if (pointer_reg == LAST) begin
                        state_reg   <= ST_DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        pointer_reg <= '0;
                    end else begin
                        pointer_reg <= pointer_reg + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign best_idx   = best_idx_reg;
    assign best_d     = best_key_reg[KW-1:KW-17];
    assign best_found = valid_reg;

endmodule

// File: tb/tb_max_select_ctrl.sv
module tb_max_select_ctrl;

    localparam int NUM = 8;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_x;
    logic [7:0]  wr_y;
    logic [3:0]  wr_w;
    logic [16:0] wr_d;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  best_idx;
    logic [16:0] best_d;
    logic        best_found;
`ifdef MAXSEL_MASK_EN
    logic [NUM-1:0] entry_en;
`endif

    max_select_ctrl #(.NUM(NUM)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_w       (wr_w),
        .wr_d       (wr_d),
        .start      (start),
`ifdef MAXSEL_MASK_EN
        .entry_en   (entry_en),
`endif
        .busy       (busy),
        .done       (done),
        .best_idx   (best_idx),
        .best_d     (best_d),
        .best_found (best_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  idx;
        logic [16:0] d;
        logic        found;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[%0t] scan done idx=%0d d=0x%0h found=%0d cycle=%0d",
                             $time, best_idx, best_d, best_found, cyc);
                    check("best_idx",   32'(best_idx),   32'(e.idx));
                    check("best_d",     32'(best_d),     32'(e.d));
                    check("best_found", 32'(best_found), 32'(e.found));
                    check("done_cycle", 32'(cyc),        32'(e.cyc));
                    check("busy_len",   32'(busy_cnt),   32'(NUM - 1));
                    check("busy_at_done", 32'(busy),     32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [7:0] x, input logic [7:0] y,
                               input logic [3:0] w, input logic [16:0] d);
        wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y; wr_w = w; wr_d = d;
        next_cycle();
        wr_en = 1'b0;
    endtask

    task automatic write_d_all(input logic [16:0] dv [NUM]);
        for (int i = 0; i < NUM; i++) write_entry(3'(i), 8'd0, 8'd0, 4'd0, dv[i]);
    endtask

    task automatic do_start(input logic [2:0] idx, input logic [16:0] d, input logic found);
        exp_t e;
        e.idx = idx; e.d = d; e.found = found; e.cyc = cyc + NUM;
        exp_q.push_back(e);
        last_exp = e;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            next_cycle();
            k++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        // Results must hold after the pulse
        repeat (3) next_cycle();
        check("hold_idx", 32'(best_idx), 32'(last_exp.idx));
        check("hold_d",   32'(best_d),   32'(last_exp.d));
    endtask

    logic [16:0] dv [NUM];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_w = '0;
        wr_d = '0; start = 1'b0;
`ifdef MAXSEL_MASK_EN
        entry_en = '1;
`endif
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Reset state
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_idx",   32'(best_idx),   32'd0);
        check("rst_d",     32'(best_d),     32'd0);
        check("rst_found", 32'(best_found), 32'd0);

        // Cleared storage: all ties, index 0 wins
        do_start(3'd0, 17'd0, 1'b1);
        wait_done();

        // d tie kept at lower index
        dv = '{17'd5, 17'd9, 17'd3, 17'd9, 17'd1, 17'd0, 17'd2, 17'd7};
        write_d_all(dv);
        do_start(3'd1, 17'd9, 1'b1);
        wait_done();

        // x tie-break, then y tie-break
        for (int i = 0; i < NUM; i++)
            write_entry(3'(i), (i == 4 || i == 6) ? 8'd10 : 8'd0, 8'd0, 4'd0, 17'd100);
        do_start(3'd4, 17'd100, 1'b1);
        wait_done();
        write_entry(3'd6, 8'd10, 8'd1, 4'd0, 17'd100);
        do_start(3'd6, 17'd100, 1'b1);
        wait_done();

        // w tie-break
        for (int i = 0; i < NUM; i++)
            write_entry(3'(i), 8'd0, 8'd0, (i == 3) ? 4'd7 : (i == 7) ? 4'd9 : 4'd0, 17'd50);
        do_start(3'd7, 17'd50, 1'b1);
        wait_done();

        // Write in the same cycle as an accepted start is dropped
        wr_en = 1'b1; wr_addr = 3'd0; wr_x = 8'hFF; wr_y = 8'hFF; wr_w = 4'hF; wr_d = 17'h1FFFF;
        do_start(3'd7, 17'd50, 1'b1);
        wr_en = 1'b0;
        wait_done();
        do_start(3'd7, 17'd50, 1'b1);
        wait_done();

        // Starts during SCAN/DONE and writes while busy are ignored
        dv = '{17'd5, 17'd9, 17'd3, 17'd9, 17'd1, 17'd0, 17'd2, 17'd7};
        write_d_all(dv);
        do_start(3'd1, 17'd9, 1'b1);            // now scan cycle 1
        wr_en = 1'b1; wr_addr = 3'd2; wr_d = 17'h1FFFF; wr_x = '0; wr_y = '0; wr_w = '0;
        next_cycle();                           // scan cycle 2
        wr_en = 1'b0;
        next_cycle();                           // scan cycle 3
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (4) next_cycle();                // cycle 8: done
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_done();
        check("no_extra_scan_busy", 32'(busy), 32'd0);
        do_start(3'd1, 17'd9, 1'b1);            // entry 2 still d=3
        wait_done();

        // Reset in scan cycle 4 aborts without done
        do_start(3'd1, 17'd9, 1'b1);            // scan cycle 1
        repeat (3) next_cycle();                // scan cycle 4
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_q.delete();
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_done",  32'(done),       32'd0);
        check("abort_idx",   32'(best_idx),   32'd0);
        check("abort_d",     32'(best_d),     32'd0);
        check("abort_found", 32'(best_found), 32'd0);
        repeat (12) next_cycle();               // monitor flags any stray done

        // Fresh load after abort
        dv = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8};
        write_d_all(dv);
        do_start(3'd7, 17'd8, 1'b1);
        wait_done();

`ifdef MAXSEL_MASK_EN
        entry_en = 8'b0000_0000;
        do_start(3'd0, 17'd0, 1'b0);
        entry_en = '1;                          // captured already
        wait_done();
        write_entry(3'd5, 8'd0, 8'd0, 4'd0, 17'd0);
        entry_en = 8'b0010_0000;
        do_start(3'd5, 17'd0, 1'b1);
        entry_en = '1;
        wait_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/max_select_ctrl.md
MAX_SELECT_CTRL -- requirements
Module: max_select_ctrl

Interface
REQ-001 The block SHALL have one parameter: NUM, default 8, meaning the number of candidate entries; index width is fixed at 3 bits, so NUM SHALL be 2..8.
REQ-002 Port list, one per line: name  direction  width  meaning, clock and reset first, as follows.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  write one candidate entry this cycle.
REQ-006 wr_addr  in  3  entry index to write.
REQ-007 wr_x / wr_y  in  8 each  candidate x and y fields.
REQ-008 wr_w  in  4  candidate w field.
REQ-009 wr_d  in  17  candidate d field (primary key).
REQ-010 start  in  1  single-cycle request to begin a scan.
REQ-011 entry_en  in  NUM  per-entry participation mask; present only with MAXSEL_MASK_EN.
REQ-012 busy  out  1  high while state is SCAN.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 best_idx  out  3  index of the winning entry; held until the next accepted start.
REQ-015 best_d  out  17  d field of the winner; held with best_idx.
REQ-016 best_found  out  1  high when at least one entry participated.

Function
REQ-017 Storage SHALL be NUM registered entries {x,y,w,d}; a write in IDLE or DONE with wr_addr<NUM SHALL update that entry at the edge; wr_addr>=NUM SHALL be ignored.
REQ-018 wr_en while busy, or in the same cycle as an accepted start, SHALL be dropped; storage SHALL stay constant during a scan.
REQ-019 FSM states: IDLE, SCAN, DONE. IDLE->SCAN on start; SCAN->DONE after the compare of entry NUM-1; DONE->IDLE unconditionally after one cycle.
REQ-020 start SHALL be accepted only in IDLE; start in SCAN or DONE SHALL be ignored with no queuing.
REQ-021 On the accepting edge the block SHALL load entry 0 as the running best, with best_idx=0, and set pointer=1.
REQ-022 In SCAN, each cycle the block SHALL compare entry[pointer] (challenger) against the running best and then increment the pointer.
REQ-023 Ordering SHALL be lexicographic, unsigned: larger d wins; if d is equal, larger x wins; then larger y; then larger w.
REQ-024 If all four fields are equal, the running best SHALL be kept, so the lower index wins.
REQ-025 Latency SHALL be fixed: done is high for exactly one cycle, in the cycle after the (NUM-1)th rising edge following the accepting edge (cycle 8 for NUM=8); busy is high for NUM-1 cycles.
REQ-026 best_idx, best_d and best_found SHALL be stable and valid when done is high, and SHALL hold until the next accepted start.
REQ-027 Back-to-back: a start sampled in the cycle done is high SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-028 On rst high at a rising edge: state=IDLE, pointer=0, all storage entries=0, busy=0, done=0, best_idx=0, best_d=0, best_found=0.
REQ-029 rst SHALL override start and wr_en in the same cycle.
REQ-030 rst mid-scan SHALL abort the scan with no done pulse; outputs SHALL take their reset values.

Configuration
REQ-031 Macro MAXSEL_MASK_EN defined: entry_en exists and is sampled at the accepting edge into a mask register.
REQ-032 With the macro, a masked-off entry SHALL never become best but SHALL still consume its scan cycle, so latency is unchanged.
REQ-033 With the macro, if entry 0 is masked, the running best SHALL start invalid and the first enabled entry SHALL become best unconditionally.
REQ-034 With the macro, if no entry is enabled: best_found=0, best_idx=0, best_d=0.
REQ-035 Macro undefined: the entry_en port is absent, all NUM entries participate, and best_found=1 at every done.

Verification
REQ-036 Write d={5,9,3,9,1,0,2,7} with x,y,w=0, then start -> done at cycle 8 after start, best_idx=1, best_d=9 (tie kept at lower index).
REQ-037 All d=100; x=10 for entry 4 and x=10 for entry 6, all other x=0 -> best_idx=4; then set y[6]=1 and rescan -> best_idx=6.
REQ-038 Pulse start at scan cycle 3 and at the done cycle, and assert wr_en with wr_addr=2, d=0x1FFFF while busy -> ignored; result unchanged; entry 2 not modified.
REQ-039 Assert rst in scan cycle 4 -> next cycle busy=0, done never pulses, all outputs 0; a fresh load and start completes normally.
REQ-040 With MAXSEL_MASK_EN: entry_en=8'b0000_0000 -> best_found=0; entry_en=8'b0010_0000 with d[5]=0 -> best_idx=5, best_found=1, done still at cycle 8.
